// File: rtl/xadc_drp_scheduler.sv
// XADC DRP read sequencer: arbitrates one DRP port between an EOC-triggered
// channel scan and a single host read port, with per-read timeout.
module xadc_drp_scheduler #(
    parameter int unsigned         NUM_CH    = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDRS  = {7'h1c, 7'h14, 7'h11, 7'h03},
    parameter int unsigned         ZERO_LSBS = 4,
    parameter int unsigned         TIMEOUT   = 64
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   eoc_in,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic                   host_req,
    input  logic [6:0]             host_addr,
    output logic                   host_gnt,
    output logic                   host_done,
    output logic [15:0]            host_data,
    output logic                   host_err,
    output logic                   drp_den,
    output logic [6:0]             drp_daddr,
    output logic                   drp_dwe,
    output logic [15:0]            drp_di,
    input  logic [15:0]            drp_do,
    input  logic                   drp_drdy,
    output logic [12*NUM_CH-1:0]   result,
    output logic [NUM_CH-1:0]      result_valid,
    output logic [NUM_CH-1:0]      result_strobe,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int unsigned SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PW = $clog2(NUM_CH + 1);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [11:0] ZMASK = 12'hFFF << ZERO_LSBS;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic            scan_active;
    logic            scan_pending;
    logic [PW-1:0]   scan_ptr;
    logic [SW-1:0]   cur_slot;
    logic            cur_host;
    logic            last_host;
    logic [CW-1:0]   wait_cnt;

    logic            n_act;
    logic            n_pend;
    logic [PW-1:0]   n_ptr;
    logic            ovr_set;
    logic [SW:0]     base_hit;
    logic [SW:0]     pick;
    logic            scan_want;
    logic [SW-1:0]   scan_idx;

    assign drp_dwe = 1'b0;
    assign drp_di  = '0;
    assign busy    = (state != IDLE) || scan_active || scan_pending;

    // Lowest enabled slot at or above base; MSB of the result flags a hit.
    function automatic logic [SW:0] find_from(input logic [PW-1:0] base,
                                              input logic [NUM_CH-1:0] mask);
        logic [SW:0] hit;
        hit = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask[i-1] && ((i - 1) >= 32'(base)))
                hit = {1'b1, SW'(i - 1)};
        end
        return hit;
    endfunction

    // Scan bookkeeping: end-of-scan / pending restart is resolved in the same
    // IDLE cycle as slot selection so masked or exhausted slots cost nothing.
    always_comb begin
        n_act    = scan_active;
        n_pend   = scan_pending;
        n_ptr    = scan_ptr;
        ovr_set  = 1'b0;
        pick     = '0;
        base_hit = find_from(scan_ptr, ch_mask);
        if (state == IDLE && scan_active && !base_hit[SW]) begin
            if (scan_pending && (|ch_mask)) begin
                n_ptr  = '0;
                n_pend = 1'b0;
            end else begin
                n_act  = 1'b0;
                n_pend = 1'b0;
            end
        end
        if (eoc_in && (|ch_mask)) begin
            if (!n_act) begin
                n_act = 1'b1;
                n_ptr = '0;
            end else if (!n_pend) begin
                n_pend = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        if (state == IDLE && n_act)
            pick = find_from(n_ptr, ch_mask);
        scan_want = pick[SW];
        scan_idx  = pick[SW-1:0];
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state         <= IDLE;
            scan_active   <= 1'b0;
            scan_pending  <= 1'b0;
            scan_ptr      <= '0;
            cur_slot      <= '0;
            cur_host      <= 1'b0;
            last_host     <= 1'b0;
            wait_cnt      <= '0;
            host_gnt      <= 1'b0;
            host_done     <= 1'b0;
            host_data     <= '0;
            host_err      <= 1'b0;
            drp_den       <= 1'b0;
            drp_daddr     <= 7'h00;
            result        <= '0;
            result_valid  <= '0;
            result_strobe <= '0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            drp_den       <= 1'b0;
            host_gnt      <= 1'b0;
            host_done     <= 1'b0;
            result_strobe <= '0;
            scan_active   <= n_act;
            scan_pending  <= n_pend;
            scan_ptr      <= n_ptr;
            if (ovr_set)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    // Host wins unless it just had the port while a scan waits.
                    if (host_req && !(last_host && scan_want)) begin
                        cur_host  <= 1'b1;
                        last_host <= 1'b1;
                        state     <= ISSUE;
                    end else if (scan_want) begin
                        cur_host  <= 1'b0;
                        last_host <= 1'b0;
                        cur_slot  <= scan_idx;
                        scan_ptr  <= PW'(scan_idx) + PW'(1);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    drp_den   <= 1'b1;
                    drp_daddr <= cur_host ? host_addr : CH_ADDRS[7*cur_slot +: 7];
                    host_gnt  <= cur_host;
                    wait_cnt  <= CW'(1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (drp_drdy) begin
                        if (cur_host) begin
                            host_data <= drp_do;
                            host_err  <= 1'b0;
                            host_done <= 1'b1;
                        end else begin
                            result[12*cur_slot +: 12] <= drp_do[15:4] & ZMASK;
                            result_valid[cur_slot]    <= 1'b1;
                            result_strobe[cur_slot]   <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        if (cur_host) begin
                            host_data <= '0;
                            host_err  <= 1'b1;
                            host_done <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xadc_drp_scheduler.md
# xadc_drp_scheduler

Sequences all reads on the XADC dynamic reconfiguration port (DRP) and shares that port between two requesters: an automatic channel scan and a single host read port. Each XADC end-of-conversion pulse triggers a scan that reads a configurable list of status registers, for example VP/VN at 7'h03 and VAUX4/VAUX12 at 7'h14/7'h1c. The scan stores 12-bit results in per-channel slots. The block sits between the xadc_wiz_0 DRP ports and consumers such as the LED PWM and data_out logic, which then read stable registers instead of driving daddr directly.

## Interface
- NUM_CH, 4, number of scan slots (1..8)
- CH_ADDRS, {7'h1c,7'h14,7'h11,7'h03}, packed 7*NUM_CH DRP addresses; slot i = CH_ADDRS[7*i+:7]
- ZERO_LSBS, 4, low bits of each 12-bit result forced to 0 (noise filter); 0..11
- TIMEOUT, 64, cycles to wait for drp_drdy before abandoning a read

Ports:
- sysclk  in  1  system clock, 100 MHz, same clock as the XADC dclk_in
- rst  in  1  synchronous, active-high reset
- eoc_in  in  1  XADC eoc_out, one-cycle pulse; triggers a scan
- ch_mask  in  NUM_CH  1 = slot enabled in scan
- host_req  in  1  host read request; held high until host_gnt
- host_addr  in  7  host DRP address; sampled on the host_gnt cycle
- host_gnt  out  1  one-cycle pulse: request accepted
- host_done  out  1  one-cycle pulse: host_data/host_err valid
- host_data  out  16  raw drp_do of the host read
- host_err  out  1  qualifies host_done: read timed out
- drp_den  out  1  DRP enable, one-cycle pulse per transaction
- drp_daddr  out  7  DRP address, held from the den cycle until the transaction ends
- drp_dwe  out  1  constant 0
- drp_di  out  16  constant 0
- drp_do  in  16  DRP read data
- drp_drdy  in  1  DRP data ready
- result  out  12*NUM_CH  slot i = result[12*i+:12]
- result_valid  out  NUM_CH  sticky: slot has been written since reset
- result_strobe  out  NUM_CH  one-cycle pulse on slot update
- overrun  out  1  sticky: eoc_in arrived while a scan was already pending
- timeout_err  out  1  sticky: any DRP read timed out
- busy  out  1  state != IDLE or scan pending

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE
  - Ignores drp_drdy.
  - Selects the next transaction. The host has priority, except that after a host transaction completes while a scan is active, the next slot goes to the scan. Host and scan alternate, so neither requester starves.
- ISSUE
  - drp_den=1 for exactly one cycle, with drp_daddr set.
  - A host transaction pulses host_gnt in the same cycle.
  - Next state: WAIT.
- WAIT
  - Counts cycles.
  - On drp_drdy, captures the data and returns to IDLE.
  - When the count reaches TIMEOUT with no drp_drdy, sets timeout_err and returns to IDLE.
- Scan start
  - eoc_in while no scan is active starts a scan at the lowest enabled slot.
  - eoc_in while a scan is active sets a one-deep pending flag.
  - eoc_in while the pending flag is already set is dropped and sets overrun.
  - At scan end, a set pending flag starts a new scan immediately.
- Slot selection
  - Enabled slots are visited in ascending index order.
  - Masked slots are skipped with zero cycle cost (next-enabled priority find).
  - ch_mask is sampled when each slot is chosen.
  - ch_mask == 0: eoc_in is ignored and no DRP traffic occurs.
- Scan result on drp_drdy
  - result slot = drp_do[15:4] with the low ZERO_LSBS bits cleared.
  - result_valid[i] is set and result_strobe[i] pulses.
- Scan timeout: the slot and its valid bit are unchanged, no strobe, and the scan advances to the next slot.
- Host result
  - On drp_drdy: host_data = drp_do, host_done=1, host_err=0.
  - On timeout: host_data = 16'h0000, host_done=1, host_err=1.
- Reset
  - All outputs go to 0, except drp_daddr = 7'h00.
  - Pending flag and scan pointer are cleared; state goes to IDLE.
  - A drp_drdy arriving after reset, from an aborted transaction, is ignored.

## Timing
- eoc_in sampled high at edge N, DRP idle: drp_den high in the cycle after edge N+1.
- drp_drdy sampled at edge M: result, result_strobe and host_done are high in the cycle after edge M, and the earliest next drp_den follows edge M+2.
- Timeout: drp_den at cycle D; the transaction is abandoned at edge D+TIMEOUT.
- drp_drdy in the same cycle the counter hits TIMEOUT counts as success.
- Back-to-back scan reads with 1-cycle drp_drdy latency: 4 cycles per slot.
- host_req and eoc_in in the same cycle from IDLE: the host is granted first and the scan follows.

## Test plan
- Scan, basic
  - Stimulus: ch_mask=4'b1111, eoc pulse, DRP model returns 16'hABCD one cycle after each den.
  - Required: 4 den pulses with daddr 03, 11, 14, 1c; each slot = 12'hAB0; result_valid=4'hF.
- Masking
  - Stimulus: ch_mask=4'b1010, eoc pulse.
  - Required: den only at 7'h11 and 7'h1c; slots 0 and 2 unchanged; ch_mask=0 with eoc gives no den.
- Arbitration
  - Stimulus: host_req at 7'h00 held during an active scan.
  - Required: host transaction is inserted between slots, then the scan resumes; host_done with host_data=raw drp_do; scan completes all slots.
- Timeout
  - Stimulus: the DRP model withholds drdy for slot 1.
  - Required: abandoned at den+64; timeout_err=1; slot 1 unchanged; slots 2 and 3 still updated; a timed-out host read gives host_err=1.
- Overrun
  - Stimulus: three eoc pulses during one scan.
  - Required: exactly one extra scan runs; overrun=1.
- Reset
  - Stimulus: rst asserted while in WAIT; late drdy after release.
  - Required: all outputs 0, no capture, next eoc scans normally.
